image_block_sequencer: RTL and testbench

IMAGE_BLOCK_SEQUENCER -- requirements
Module: image_block_sequencer

---
 rtl/image_block_sequencer_pkg.sv | 21 ++
 rtl/cipher_out_fifo.sv | 65 ++++++
 rtl/image_block_sequencer.sv | 174 +++++++++++++++++
 tb/tb_image_block_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_block_sequencer_pkg.sv
// Shared definitions for the image block sequencer and its output FIFO.
package image_block_sequencer_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 256;
   localparam int unsigned DEFAULT_CNT_WIDTH  = 16;
   localparam int unsigned DEFAULT_DEPTH      = 8;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_KEY,
      ISSUE,
      DRAIN,
      FINISH
   } seq_state_t;

   // Bits needed to hold a credit/occupancy value in the range 0..depth.
   function automatic int unsigned credit_bits(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/cipher_out_fifo.sv
// Synchronous first-word-fall-through FIFO holding returned ciphertext blocks.
module cipher_out_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 256
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == FULL_COUNT);
   assign count     = r_count;
   assign head_data = r_mem[r_rd_ptr];

   // A pop frees a slot in the same cycle, so a full FIFO can accept a push alongside it.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   // Storage write; contents need no reset since occupancy is tracked separately.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/image_block_sequencer.sv
// Sequences plaintext blocks into a CTR encrypt core under a credit scheme and
// buffers the returned ciphertext for the downstream sink.
module image_block_sequencer
   import image_block_sequencer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH,
   parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  num_blocks,
   input  logic                  key_ready,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  core_tvalid,
   output logic [DATA_WIDTH-1:0] core_plaintext,
   input  logic                  core_valid,
   input  logic [DATA_WIDTH-1:0] core_ciphertext,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);

   localparam int unsigned CRW = credit_bits(DEPTH);
   localparam logic [CRW-1:0] CREDIT_INIT = CRW'(DEPTH);

   seq_state_t            r_state;
   seq_state_t            w_state_nxt;
   logic [CNT_WIDTH-1:0]  r_remaining;
   logic [CNT_WIDTH-1:0]  r_issued;
   logic [CNT_WIDTH-1:0]  r_returned;
   logic [CNT_WIDTH-1:0]  r_job_len;
   logic [CRW-1:0]        r_credits;
   logic                  r_overflow;

   logic                  w_load;
   logic                  w_can_issue;
   logic                  w_issue;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic [CRW-1:0]        w_fifo_count;

   assign w_load      = (r_state == IDLE) && start;
   assign w_can_issue = (r_state == ISSUE) && key_ready
                        && (r_remaining != '0) && (r_credits != '0);
   assign w_issue     = in_valid && w_can_issue;
   assign w_pop       = !w_fifo_empty && out_ready;

   // A result is accepted only if a block is outstanding and the FIFO has room
   // (a simultaneous pop counts as room); anything else is dropped as overflow.
   assign w_push      = core_valid && (r_returned != r_issued)
                        && (!w_fifo_full || w_pop);
   assign w_drop      = core_valid && !w_push;

   assign in_ready       = w_can_issue;
   assign core_tvalid    = w_issue;
   assign core_plaintext = w_issue ? in_data : '0;
   assign out_valid      = !w_fifo_empty;
   assign busy           = (r_state != IDLE);
   assign done           = (r_state == FINISH);
   assign overflow       = r_overflow;

   cipher_out_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_out_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (w_push),
      .push_data (core_ciphertext),
      .pop       (w_pop),
      .head_data (out_data),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty),
      .count     (w_fifo_count)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = (num_blocks == '0) ? FINISH : WAIT_KEY;
            end
         end
         WAIT_KEY: begin
            if (key_ready) begin
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (w_issue && (r_remaining == CNT_WIDTH'(1))) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if ((r_returned == r_job_len) && (w_fifo_count == '0)) begin
               w_state_nxt = FINISH;
            end
         end
         FINISH: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Job length latch and issued/returned block counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_remaining <= '0;
         r_issued    <= '0;
         r_returned  <= '0;
         r_job_len   <= '0;
      end else if (w_load) begin
         r_remaining <= num_blocks;
         r_job_len   <= num_blocks;
         r_issued    <= '0;
         r_returned  <= '0;
      end else begin
         if (w_issue) begin
            r_remaining <= r_remaining - CNT_WIDTH'(1);
            r_issued    <= r_issued + CNT_WIDTH'(1);
         end
         if (w_push) begin
            r_returned <= r_returned + CNT_WIDTH'(1);
         end
      end
   end

   // Credits bound in-flight plus buffered blocks to the FIFO depth.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_credits <= CREDIT_INIT;
      end else begin
         case ({w_issue, w_pop})
            2'b10:   r_credits <= r_credits - CRW'(1);
            2'b01:   r_credits <= r_credits + CRW'(1);
            default: r_credits <= r_credits;
         endcase
      end
   end

   // Sticky overflow flag for dropped core results.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_image_block_sequencer.sv
// Self-checking bench for image_block_sequencer with a behavioural core and sink model.
module tb_image_block_sequencer;

   localparam int DW    = 256;
   localparam int CW    = 16;
   localparam int DEPTH = 8;
   localparam logic [DW-1:0] KEY = {8{32'h5A3C_96E1}};

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] num_blocks = '0;
   logic          key_ready = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          core_tvalid;
   logic [DW-1:0] core_plaintext;
   logic          core_valid = 1'b0;
   logic [DW-1:0] core_ciphertext = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          busy;
   logic          done;
   logic          overflow;

   image_block_sequencer #(
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .num_blocks      (num_blocks),
      .key_ready       (key_ready),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .core_tvalid     (core_tvalid),
      .core_plaintext  (core_plaintext),
      .core_valid      (core_valid),
      .core_ciphertext (core_ciphertext),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .busy            (busy),
      .done            (done),
      .overflow        (overflow)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state: source blocks of the current job, expected sink
   // sequence, and the in-flight core pipeline.
   typedef struct {
      int            due;
      logic [DW-1:0] pt;
   } core_item_t;

   logic [DW-1:0] src_q[$];
   logic [DW-1:0] exp_q[$];
   core_item_t    core_q[$];
   int            issue_cyc[$];
   int            lat = 30;
   int            issues = 0;
   int            outs = 0;
   int            done_cnt = 0;
   int            key_mode = 1;     // 0 low, 1 high, 2 random
   int            ready_mode = 1;   // 0 low, 1 high, 2 random
   bit            valid_rand = 1'b0;
   int            inject_at = -1;

   function automatic logic [DW-1:0] cipher(input logic [DW-1:0] p);
      return {p[DW-9:0], p[DW-1:DW-8]} ^ KEY;
   endfunction

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] r = '0;
      for (int i = 0; i < DW / 32; i++) r = {r[DW-33:0], 32'($urandom())};
      return r;
   endfunction

   // Source, key and sink-ready drivers.
   always @(negedge clk) begin
      case (key_mode)
         0:       key_ready = 1'b0;
         1:       key_ready = 1'b1;
         default: key_ready = ($urandom_range(3) != 0);
      endcase
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(2) != 0);
      endcase
      if (issues < src_q.size()) begin
         in_valid = valid_rand ? ($urandom_range(1) == 1) : 1'b1;
         in_data  = src_q[issues];
      end else begin
         in_valid = 1'b0;
         in_data  = rand_word();
      end
   end

   // Encrypt core model: fixed latency, no backpressure.
   always @(posedge clk) begin
      #1;
      core_valid      = 1'b0;
      core_ciphertext = '0;
      if (cyc == inject_at) begin
         core_valid      = 1'b1;
         core_ciphertext = rand_word();
      end else if (core_q.size() > 0 && core_q[0].due <= cyc) begin
         core_valid      = 1'b1;
         core_ciphertext = cipher(core_q[0].pt);
         void'(core_q.pop_front());
      end
   end

   // Streaming monitor: issue order, key gating, credit bound and sink order.
   always @(negedge clk) begin
      logic [DW-1:0] want;
      #2;
      if (reset_n === 1'b1) begin
         if (core_tvalid === 1'b1) begin
            checks++;
            if (issues >= src_q.size()) begin
               errors++;
               $display("FAIL issue_extra: issue #%0d but job has %0d blocks", issues, src_q.size());
            end else begin
               if (core_plaintext !== src_q[issues]) begin
                  errors++;
                  $display("FAIL issue_data: got %h want %h", core_plaintext, src_q[issues]);
               end
               exp_q.push_back(cipher(src_q[issues]));
            end
            checks++;
            if (key_ready !== 1'b1) begin
               errors++;
               $display("FAIL issue_key_low: key_ready=%b during issue, want 1", key_ready);
            end
            core_q.push_back('{due: cyc + lat, pt: core_plaintext});
            issue_cyc.push_back(cyc);
            issues++;
            checks++;
            if (issues - outs > DEPTH) begin
               errors++;
               $display("FAIL credit_limit: in-flight %0d, want <= %0d", issues - outs, DEPTH);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL out_extra: unexpected output %h", out_data);
            end else begin
               want = exp_q.pop_front();
               if (out_data !== want) begin
                  errors++;
                  $display("FAIL out_data: got %h want %h", out_data, want);
               end
            end
            outs++;
         end
         if (done === 1'b1) done_cnt++;
      end
   end

   task automatic tick();
      @(negedge clk);
      #3;
   endtask

   task automatic clear_model();
      src_q.delete();
      exp_q.delete();
      issue_cyc.delete();
      issues   = 0;
      outs     = 0;
      done_cnt = 0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_model();
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic start_job(input int n, input int l);
      clear_model();
      lat = l;
      for (int i = 0; i < n; i++) src_q.push_back(rand_word());
      num_blocks = CW'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int  n = 0;
      bit  seen = 1'b0;
      while (n < budget && !seen) begin
         tick();
         n++;
         if (done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: done=0 after %0d cycles, want 1", tag, budget);
      end else begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_at_done: got %b want 1", tag, busy);
         end
         tick();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done: done=%b busy=%b want 0 0", tag, done, busy);
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      checks++; if (core_tvalid !== 1'b0) begin errors++; $display("FAIL rst_core_tvalid: got %b want 0", core_tvalid); end
      checks++; if (core_plaintext !== '0) begin errors++; $display("FAIL rst_core_pt: got %h want 0", core_plaintext); end
      checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0)        begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
      do_reset();
   endtask

   task automatic test_basic();
      key_mode = 1; ready_mode = 1; valid_rand = 1'b0;
      start_job(3, 30);
      // A second start while busy must be ignored.
      num_blocks = CW'(7);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(200, "basic");
      tick();
      checks++; if (issues != 3) begin errors++; $display("FAIL basic_issues: got %0d want 3", issues); end
      checks++; if (outs != 3)   begin errors++; $display("FAIL basic_outs: got %0d want 3", outs); end
      checks++;
      if (issue_cyc.size() != 3 || issue_cyc[1] != issue_cyc[0] + 1 || issue_cyc[2] != issue_cyc[1] + 1) begin
         errors++;
         $display("FAIL basic_consecutive: issue cycles not back-to-back (%0d issues)", issue_cyc.size());
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b want 0", overflow); end
   endtask

   task automatic test_zero_blocks();
      start_job(0, 30);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_after: done=%b busy=%b want 0 0", done, busy);
      end
      checks++; if (issues != 0) begin errors++; $display("FAIL zero_issues: got %0d want 0", issues); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
   endtask

   task automatic test_backpressure();
      ready_mode = 0;
      start_job(20, 30);
      repeat (60) tick();
      checks++; if (issues != DEPTH) begin errors++; $display("FAIL bp_issues: got %0d want %0d", issues, DEPTH); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
      ready_mode = 1;
      wait_done(600, "bp");
      checks++; if (outs != 20) begin errors++; $display("FAIL bp_outs: got %0d want 20", outs); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow: got %b want 0", overflow); end
   endtask

   task automatic test_key_late();
      int key_cyc;
      key_mode = 0;
      start_job(5, 30);
      repeat (50) tick();
      checks++; if (issues != 0) begin errors++; $display("FAIL key_early_issue: got %0d want 0", issues); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL key_wait_busy: got %b want 1", busy); end
      key_mode = 1;
      tick();
      key_cyc = cyc;
      wait_done(300, "key");
      checks++;
      if (issue_cyc.size() == 0 || issue_cyc[0] <= key_cyc) begin
         errors++;
         $display("FAIL key_first_issue: first issue not after key cycle %0d (%0d issues)", key_cyc, issue_cyc.size());
      end
      checks++; if (outs != 5) begin errors++; $display("FAIL key_outs: got %0d want 5", outs); end
   endtask

   task automatic test_random_jobs();
      int n;
      for (int j = 0; j < 4; j++) begin
         key_mode = 2; ready_mode = 2; valid_rand = 1'b1;
         n = $urandom_range(24, 1);
         start_job(n, $urandom_range(40, 1));
         wait_done(3000, "rand");
         checks++; if (outs != n) begin errors++; $display("FAIL rand_outs: got %0d want %0d", outs, n); end
         checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand_done_count: got %0d want 1", done_cnt); end
         checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow: got %b want 0", overflow); end
      end
      key_mode = 1; ready_mode = 1; valid_rand = 1'b0;
   endtask

   task automatic test_spurious();
      inject_at = cyc + 1;
      tick();
      tick();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL spur_overflow: got %b want 1", overflow); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL spur_out_valid: got %b want 0", out_valid); end
      tick();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL spur_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_reset_midjob();
      int guard = 0;
      do_reset();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_pre_overflow: got %b want 0", overflow); end
      start_job(10, 30);
      while (issues < 4 && guard < 50) begin
         tick();
         guard++;
      end
      checks++; if (issues != 4) begin errors++; $display("FAIL mid_inflight: got %0d want 4", issues); end
      reset_n = 1'b0;
      clear_model();
      #1;
      checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
      checks++; if (core_tvalid !== 1'b0)  begin errors++; $display("FAIL mid_core_tvalid: got %b want 0", core_tvalid); end
      checks++; if (core_plaintext !== '0) begin errors++; $display("FAIL mid_core_pt: got %h want 0", core_plaintext); end
      checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0)         begin errors++; $display("FAIL mid_done: got %b want 0", done); end
      checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL mid_overflow: got %b want 0", overflow); end
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (40) tick();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_stale_overflow: got %b want 1", overflow); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_out_valid: got %b want 0", out_valid); end
      do_reset();
      start_job(6, 30);
      wait_done(300, "post");
      checks++; if (outs != 6) begin errors++; $display("FAIL post_outs: got %0d want 6", outs); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL post_overflow: got %b want 0", overflow); end
   endtask

   initial begin
      #400000;
      errors++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_zero_blocks();
      test_backpressure();
      test_key_late();
      test_random_jobs();
      test_spurious();
      test_reset_midjob();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
